// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
//   state_t              : controller FSM states
//   COUNT_W              : width of the internal iteration counter
//   *_CYCLES_DEFAULT     : count values presented to each datapath
package multdiv_pkg;

   localparam int unsigned COUNT_W             = 6;
   localparam int unsigned DATA_W              = 32;
   localparam int unsigned MULT_CYCLES_DEFAULT = 17;
   localparam int unsigned DIV_CYCLES_DEFAULT  = 33;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MULT  = 3'd1,
      ST_DIV   = 3'd2,
      ST_DZERO = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/op_counter.sv
// Iteration counter shared by the multiply and divide sequences.
//   clk, reset_n : clock, async active-low reset
//   i_clr        : synchronous clear (wins over i_en)
//   i_en         : increment enable
//   i_limit      : runtime terminal value
//   o_count      : current count
//   o_terminal   : high while o_count equals i_limit
module op_counter #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_limit,
   output logic [W-1:0] o_count,
   output logic         o_terminal
);

   logic [W-1:0] r_count;

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == i_limit);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide datapath. Latches operands on a
// start pulse, drives the iteration count into the selected datapath,
// captures its result/exception on the final iteration and strobes ready.
//   clk, reset_n              : clock, async active-low reset
//   ctrl_MULT, ctrl_DIV       : start pulses (MULT wins when both)
//   data_operandA/B           : operands, sampled with a start pulse
//   opA_q, opB_q, count       : registered operands and iteration index
//   mult_en, div_en           : datapath selects
//   mult_product, mult_ovf    : multiplier result
//   div_quot, div_exc         : divider result
//   data_result/exception     : held result, updated only on capture
//   data_resultRDY            : one-cycle completion strobe
//   busy                      : operation in flight
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] opA_q,
   output logic [31:0] opB_q,
   output logic [31:0] count,
   output logic        mult_en,
   output logic        div_en,
   input  logic [31:0] mult_product,
   input  logic        mult_ovf,
   input  logic [31:0] div_quot,
   input  logic        div_exc,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_opa;
   logic [DATA_W-1:0]   r_opb;
   logic [DATA_W-1:0]   r_result;
   logic                r_exc;
   logic                r_rdy;
   logic                r_busy;
   logic                r_mult_en;
   logic                r_div_en;

   logic                w_start;
   logic                w_counting;
   logic [COUNT_W-1:0]  w_limit;
   logic [COUNT_W-1:0]  w_cnt;
   logic                w_terminal;
   logic                w_cap;
   logic [DATA_W-1:0]   w_cap_result;
   logic                w_cap_exc;
   logic                w_mult_en_nxt;
   logic                w_div_en_nxt;
   logic                w_busy_nxt;
   logic                w_rdy_nxt;

   assign w_start    = ctrl_MULT | ctrl_DIV;
   assign w_counting = (r_state == ST_MULT) || (r_state == ST_DIV);
   assign w_limit    = (r_state == ST_DIV) ? COUNT_W'(DIV_CYCLES - 1)
                                           : COUNT_W'(MULT_CYCLES - 1);

   // Count held at 0 outside MULT/DIV; restarted by any start or on the last step
   op_counter #(.W(COUNT_W)) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clr      (w_start | ~w_counting | w_terminal),
      .i_en       (w_counting),
      .i_limit    (w_limit),
      .o_count    (w_cnt),
      .o_terminal (w_terminal)
   );

   // State register plus registered operands, result and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_opa     <= '0;
         r_opb     <= '0;
         r_result  <= '0;
         r_exc     <= 1'b0;
         r_rdy     <= 1'b0;
         r_busy    <= 1'b0;
         r_mult_en <= 1'b0;
         r_div_en  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rdy     <= w_rdy_nxt;
         r_busy    <= w_busy_nxt;
         r_mult_en <= w_mult_en_nxt;
         r_div_en  <= w_div_en_nxt;
         if (w_start) begin
            r_opa <= data_operandA;
            r_opb <= data_operandB;
         end
         if (w_cap) begin
            r_result <= w_cap_result;
            r_exc    <= w_cap_exc;
         end
      end
   end

   // Next-state logic; a start pulse overrides whatever is in flight
   always_comb begin
      w_state_nxt = r_state;
      if (ctrl_MULT) begin
         w_state_nxt = ST_MULT;
      end else if (ctrl_DIV) begin
         w_state_nxt = (data_operandB == '0) ? ST_DZERO : ST_DIV;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_MULT:  if (w_terminal) w_state_nxt = ST_DONE;
            ST_DIV:   if (w_terminal) w_state_nxt = ST_DONE;
            ST_DZERO: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output logic: next-cycle status and result capture (aborted ops never capture)
   always_comb begin
      w_mult_en_nxt = (w_state_nxt == ST_MULT);
      w_div_en_nxt  = (w_state_nxt == ST_DIV);
      w_busy_nxt    = (w_state_nxt == ST_MULT) || (w_state_nxt == ST_DIV) ||
                      (w_state_nxt == ST_DZERO);
      w_rdy_nxt     = (w_state_nxt == ST_DONE);
      w_cap         = 1'b0;
      w_cap_result  = '0;
      w_cap_exc     = 1'b0;
      if (!w_start) begin
         case (r_state)
            ST_MULT: begin
               w_cap        = w_terminal;
               w_cap_result = mult_product;
               w_cap_exc    = mult_ovf;
            end
            ST_DIV: begin
               w_cap        = w_terminal;
               w_cap_result = div_quot;
               w_cap_exc    = div_exc;
            end
            ST_DZERO: begin
               w_cap        = 1'b1;
               w_cap_result = '0;
               w_cap_exc    = 1'b1;
            end
            default: begin
               w_cap = 1'b0;
            end
         endcase
      end
   end

   assign opA_q          = r_opa;
   assign opB_q          = r_opb;
   assign count          = DATA_W'(w_cnt);
   assign mult_en        = r_mult_en;
   assign div_en         = r_div_en;
   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = r_rdy;
   assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with stub multiplier/divider datapaths.
module tb_multdiv_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] opA_q;
   logic [31:0] opB_q;
   logic [31:0] count;
   logic        mult_en;
   logic        div_en;
   logic [31:0] mult_product;
   logic        mult_ovf;
   logic [31:0] div_quot;
   logic        div_exc;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   logic        stub_ovf;

   int          n_chk;
   int          n_fail;
   int          cyc;
   int          rdy_n;
   int          rdy_cyc;
   int          mult_en_n;
   int          div_en_n;
   int          busy_n;
   int          seq_err;
   int          max_cnt;
   logic        busy_at_rdy;
   logic        prev_en;
   logic [31:0] prev_cnt;

   multdiv_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .opA_q          (opA_q),
      .opB_q          (opB_q),
      .count          (count),
      .mult_en        (mult_en),
      .div_en         (div_en),
      .mult_product   (mult_product),
      .mult_ovf       (mult_ovf),
      .div_quot       (div_quot),
      .div_exc        (div_exc),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Stub datapaths: valid answer only on the final count, garbage otherwise
   always_comb begin
      mult_product = (mult_en && count == 32'd16) ? opA_q * opB_q : 32'h0BAD_0BAD;
      mult_ovf     = stub_ovf && mult_en && (count == 32'd16);
      div_quot     = (div_en && count == 32'd32 && opB_q != 32'd0) ? opA_q / opB_q
                                                                  : 32'h0D1E_0D1E;
      div_exc      = 1'b0;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic clear_stats();
      cyc         = 0;
      rdy_n       = 0;
      rdy_cyc     = 0;
      mult_en_n   = 0;
      div_en_n    = 0;
      busy_n      = 0;
      seq_err     = 0;
      max_cnt     = 0;
      busy_at_rdy = 1'b0;
      prev_en     = 1'b0;
      prev_cnt    = 32'd0;
   endtask

   // Advance one cycle and observe outputs at the falling edge
   task automatic step();
      @(negedge clk);
      cyc++;
      if (data_resultRDY) begin
         rdy_n++;
         if (rdy_n == 1) rdy_cyc = cyc;
         busy_at_rdy = busy;
      end
      if (mult_en) mult_en_n++;
      if (div_en)  div_en_n++;
      if (busy)    busy_n++;
      if (mult_en || div_en) begin
         if (prev_en ? (count != prev_cnt + 32'd1) : (count != 32'd0)) seq_err++;
         if (int'(count) > max_cnt) max_cnt = int'(count);
         prev_cnt = count;
         prev_en  = 1'b1;
      end else begin
         prev_en = 1'b0;
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Drive a one-cycle start pulse; returns observing cycle 1 after the start
   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      prev_en       = 1'b0;
      step();
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      reset_n       = 1'b0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      stub_ovf      = 1'b0;
      clear_stats();

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_count",  count, 32'd0);
      check_eq("rst_opA",    opA_q, 32'd0);
      check_eq("rst_opB",    opB_q, 32'd0);
      check_eq("rst_result", data_result, 32'd0);
      check_eq("rst_flags",  32'({data_exception, data_resultRDY, busy, mult_en, div_en}), 32'd0);
      reset_n = 1'b1;

      // Multiply 7 * -3
      clear_stats();
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      run(25);
      check_eq("mul_rdy_cyc", 32'(rdy_cyc), 32'd18);
      check_eq("mul_rdy_n",   32'(rdy_n), 32'd1);
      check_eq("mul_result",  data_result, 32'hFFFF_FFEB);
      check_eq("mul_exc",     32'(data_exception), 32'd0);
      check_eq("mul_busy_rdy", 32'(busy_at_rdy), 32'd0);
      check_eq("mul_en_n",    32'(mult_en_n), 32'd17);
      check_eq("mul_div_en_n", 32'(div_en_n), 32'd0);
      check_eq("mul_seq",     32'(seq_err), 32'd0);
      check_eq("mul_max_cnt", 32'(max_cnt), 32'd16);

      // Divide 100 / 7
      clear_stats();
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      run(40);
      check_eq("div_rdy_cyc", 32'(rdy_cyc), 32'd34);
      check_eq("div_rdy_n",   32'(rdy_n), 32'd1);
      check_eq("div_result",  data_result, 32'd14);
      check_eq("div_exc",     32'(data_exception), 32'd0);
      check_eq("div_en_n",    32'(div_en_n), 32'd33);
      check_eq("div_mult_en_n", 32'(mult_en_n), 32'd0);
      check_eq("div_seq",     32'(seq_err), 32'd0);
      check_eq("div_max_cnt", 32'(max_cnt), 32'd32);

      // Divide by zero
      clear_stats();
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      run(5);
      check_eq("dz_rdy_cyc", 32'(rdy_cyc), 32'd2);
      check_eq("dz_rdy_n",   32'(rdy_n), 32'd1);
      check_eq("dz_result",  data_result, 32'd0);
      check_eq("dz_exc",     32'(data_exception), 32'd1);
      check_eq("dz_div_en_n", 32'(div_en_n), 32'd0);
      check_eq("dz_busy_n",  32'(busy_n), 32'd1);

      // Result holds across a new start; overflow flag captured from multiplier
      clear_stats();
      stub_ovf = 1'b1;
      start_op(1'b1, 1'b0, 32'd3, 32'd5);
      run(4);
      check_eq("hold_result", data_result, 32'd0);
      check_eq("hold_exc",    32'(data_exception), 32'd1);
      run(20);
      check_eq("ovf_rdy_cyc", 32'(rdy_cyc), 32'd18);
      check_eq("ovf_result",  data_result, 32'd15);
      check_eq("ovf_exc",     32'(data_exception), 32'd1);
      stub_ovf = 1'b0;

      // Restart: multiply at cycle 0, divide 9/3 at cycle 5
      clear_stats();
      start_op(1'b1, 1'b0, 32'd2, 32'd2);
      run(4);
      start_op(1'b0, 1'b1, 32'd9, 32'd3);
      check_eq("rs_cyc6_count",  count, 32'd0);
      check_eq("rs_cyc6_div_en", 32'(div_en), 32'd1);
      check_eq("rs_cyc6_mult_en", 32'(mult_en), 32'd0);
      check_eq("rs_opA",         opA_q, 32'd9);
      run(40);
      check_eq("rs_rdy_n",   32'(rdy_n), 32'd1);
      check_eq("rs_rdy_cyc", 32'(rdy_cyc), 32'd39);
      check_eq("rs_result",  data_result, 32'd3);
      check_eq("rs_exc",     32'(data_exception), 32'd0);
      check_eq("rs_seq",     32'(seq_err), 32'd0);

      // Simultaneous pulses: multiply wins
      clear_stats();
      start_op(1'b1, 1'b1, 32'd6, 32'd4);
      run(25);
      check_eq("sim_rdy_cyc", 32'(rdy_cyc), 32'd18);
      check_eq("sim_div_en_n", 32'(div_en_n), 32'd0);
      check_eq("sim_mult_en_n", 32'(mult_en_n), 32'd17);
      check_eq("sim_result",  data_result, 32'd24);

      // Asynchronous reset mid-multiply
      clear_stats();
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      run(9);
      check_eq("ar_pre_count", count, 32'd9);
      #2 reset_n = 1'b0;
      #1;
      check_eq("ar_count",  count, 32'd0);
      check_eq("ar_opA",    opA_q, 32'd0);
      check_eq("ar_opB",    opB_q, 32'd0);
      check_eq("ar_result", data_result, 32'd0);
      check_eq("ar_flags",  32'({data_exception, data_resultRDY, busy, mult_en, div_en}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      clear_stats();
      run(30);
      check_eq("ar_no_rdy",  32'(rdy_n), 32'd0);
      check_eq("ar_no_busy", 32'(busy_n), 32'd0);
      clear_stats();
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      run(25);
      check_eq("ar_mul_rdy_cyc", 32'(rdy_cyc), 32'd18);
      check_eq("ar_mul_rdy_n",   32'(rdy_n), 32'd1);
      check_eq("ar_mul_result",  data_result, 32'hFFFF_FFEB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the shared multiply/divide datapath. It latches operands on a start pulse and drives the iteration `count` bus into the radix-4 Booth multiplier or the restoring divider. It captures the selected unit's result and exception flag when the iteration count completes, and presents them with a one-cycle ready strobe. It sits between the processor's execute stage and the `mult`/`div` datapaths, and it is the only block that advances their counters.

## Interface
Parameters:
- `MULT_CYCLES`, 17: count values presented to the multiplier (1 load + 16 Booth steps).
- `DIV_CYCLES`, 33: count values presented to the divider (1 load + 32 steps).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ctrl_MULT` in 1: one-cycle start pulse for multiply.
- `ctrl_DIV` in 1: one-cycle start pulse for divide.
- `data_operandA` in 32: multiplicand / dividend, sampled with a start pulse.
- `data_operandB` in 32: multiplier / divisor, sampled with a start pulse.
- `opA_q`, `opB_q` out 32 each: latched operands, driven to both datapaths.
- `count` out 32: iteration index. Bits [31:5] are always 0 for mult; bits [31:6] are always 0 for div.
- `mult_en`, `div_en` out 1: select the active datapath. Mutually exclusive.
- `mult_product` in 32, `mult_ovf` in 1: multiplier outputs.
- `div_quot` in 32, `div_exc` in 1: divider outputs.
- `data_result` out 32: held result.
- `data_exception` out 1: held exception (overflow or divide-by-zero).
- `data_resultRDY` out 1: one-cycle completion strobe.
- `busy` out 1: high while an operation is in flight.

## Operation
- FSM states: IDLE, MULT, DIV, DZERO, DONE.
- **IDLE:** count=0, enables low.
- **Start sampling:** on an edge with `ctrl_MULT`=1, latch both operands, go to MULT, count=0. On an edge with `ctrl_DIV`=1, latch both operands:
  - if `data_operandB`==0, go to DZERO;
  - otherwise go to DIV, count=0.
- **Both pulses on the same edge:** MULT wins; `ctrl_DIV` is ignored.
- **Start accepted in any state**, including MULT, DIV and DONE. The in-flight operation is aborted, its result is never published, operands are re-latched, and count restarts at 0.
- **MULT/DIV:** count increments by 1 each cycle. On the edge where count==N−1 (N = MULT_CYCLES or DIV_CYCLES):
  - `data_result` ← product/quotient;
  - `data_exception` ← `mult_ovf`/`div_exc`;
  - go to DONE, count ← 0.
- **DZERO:** lasts one cycle. Captures `data_result`=0 and `data_exception`=1, then goes to DONE.
- **DONE:** lasts one cycle with `data_resultRDY`=1, then goes to IDLE.
- **Result holding:** `data_result` and `data_exception` hold until the next capture. A new start does not clear them.
- **Count width:** count never exceeds N−1; no wrap-around occurs.
- **Enables:** `mult_en`=1 only in MULT; `div_en`=1 only in DIV.
- **`busy`:** 1 in MULT, DIV and DZERO.

## Timing
- **Reset values:** state IDLE; every output 0, including `opA_q`, `opB_q`, `count`, `data_result`, `data_exception`, `data_resultRDY`, `busy`, `mult_en`, `div_en`.
- **Reset assertion mid-operation:** takes effect immediately and asynchronously. No ready strobe is produced.
- **Normal latency:** start sampled at edge E0. count=0 is visible in the cycle after E0. `data_resultRDY` is high in the cycle following edge E0+N.
  - Multiply (N=17): `data_resultRDY` is high in cycle 18 after the start.
  - Divide (N=33): `data_resultRDY` is high in cycle 34 after the start.
- **Divide-by-zero:** `data_resultRDY` is high in cycle 2 after the start.
- **Data valid:** `data_result` is valid in the same cycle as `data_resultRDY` and remains valid afterwards.
- **Fixed latency:** there is no backpressure; the consumer must sample on the strobe.
- **Datapath timing:** both datapaths take `count` and operands combinationally from registered controller outputs. The controller's result capture is purely registered.

## Structure
- **`multdiv_pkg`:**
  - state enum (IDLE, MULT, DIV, DZERO, DONE);
  - default constants MULT_CYCLES=17 and DIV_CYCLES=33;
  - COUNT_W=6.
- **`op_counter` sub-module:**
  - resettable counter with synchronous clear and enable;
  - a `terminal` output that compares against a runtime limit.
  - One instance, shared by both operation types.
- **Controller body:** FSM, operand registers, result/exception registers.

## Test plan
- **Multiply:** A=7, B=−3, `ctrl_MULT` pulse, stub multiplier returns −21 at count 16 → `data_resultRDY` in cycle 18, result 0xFFFFFFEB, exception 0, `busy` low in cycle 18.
- **Divide:** A=100, B=7, `ctrl_DIV` pulse, stub divider returns 14 → ready in cycle 34, result 14, count sweeps 0..32 exactly once.
- **Divide-by-zero:** A=5, B=0, `ctrl_DIV` → ready in cycle 2, result 0, exception 1, `div_en` never asserted.
- **Restart:** `ctrl_MULT` at cycle 0, then `ctrl_DIV` with A=9, B=3 at cycle 5 → no strobe for the multiply, count resets to 0 at cycle 6, single ready at cycle 39 with result 3.
- **Simultaneous start:** `ctrl_MULT` and `ctrl_DIV` on the same edge → MULT path taken, `div_en` stays 0, ready in cycle 18.
- **Reset:** `reset_n` dropped mid-MULT at count 9 → all outputs 0 immediately. No strobe after release. A new `ctrl_MULT` produces a normal 18-cycle result.
